// File: rtl/stack_calc_pkg.sv
// rtl/stack_calc_pkg.sv - op codes, evaluator states and precedence shared by the calculator blocks
package stack_calc_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_EQ  = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_PUSH_OP,
    ST_FINAL,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic prec(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_EQ);
  endfunction

endpackage

// File: rtl/stack_evaluator_if.sv
// rtl/stack_evaluator_if.sv - token/result handshake between the sequencer and stack_evaluator
interface stack_evaluator_if #(
  parameter int WIDTH = 32
);
  logic             tok_valid;
  logic [WIDTH-1:0] tok_number;
  logic [3:0]       tok_op;
  logic             tok_ready;
  logic             calc_ready;
  logic             is_equal;
  logic [WIDTH-1:0] calc_answer;
  logic             calc_error;

  modport master (
    output tok_valid, tok_number, tok_op,
    input  tok_ready, calc_ready, is_equal, calc_answer, calc_error
  );

  modport slave (
    input  tok_valid, tok_number, tok_op,
    output tok_ready, calc_ready, is_equal, calc_answer, calc_error
  );
endinterface

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - combinational signed ALU for one stack reduction (a OP b)
module stack_alu
  import stack_calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [3:0]              op,
  output logic signed [WIDTH-1:0] result,
  output logic                    div_by_zero
);

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_DIV: begin
        if (b == '0) begin
          div_by_zero = 1'b1;
        end else if (b == '1) begin
          // MIN / -1 must wrap to MIN rather than trap
          result = -a;
        end else begin
          result = a / b;
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_evaluator.sv
// rtl/stack_evaluator.sv - shunting-yard infix evaluator with two precedence levels
module stack_evaluator
  import stack_calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  stack_evaluator_if.slave bus
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [PW-1:0] TWO  = PW'(2);

  state_t state, state_n;

  logic signed [WIDTH-1:0] opnd [DEPTH];
  logic [3:0]              ops  [DEPTH];
  logic [PW-1:0]           opnd_ptr, op_ptr, base_ptr;
  logic [3:0]              op_q;
  logic [IW-1:0]           base_i, top_i, next_i, op_top_i, op_push_i;
  logic [3:0]              top_op;
  logic signed [WIDTH-1:0] alu_result;
  logic                    div_by_zero;
  logic                    tok_ready, accept, push_num, do_reduce, push_op, do_final;
  logic                    calc_ready_q, is_equal_q, calc_error_q;
  logic [WIDTH-1:0]        calc_answer_q;

  assign tok_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = bus.tok_valid && tok_ready;

  // A token accepted in DONE starts a fresh expression on empty stacks
  assign base_ptr  = (state == ST_DONE) ? '0 : opnd_ptr;
  assign base_i    = IW'(base_ptr);
  assign top_i     = IW'(opnd_ptr - PW'(1));
  assign next_i    = IW'(opnd_ptr - PW'(2));
  assign op_top_i  = IW'(op_ptr - PW'(1));
  assign op_push_i = IW'(op_ptr);
  assign top_op    = ops[op_top_i];

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .a           (opnd[next_i]),
    .b           (opnd[top_i]),
    .op          (top_op),
    .result      (alu_result),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    push_num  = 1'b0;
    do_reduce = 1'b0;
    push_op   = 1'b0;
    do_final  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (base_ptr == FULL) begin
            state_n = ST_ERROR;
          end else begin
            push_num = 1'b1;
            state_n  = op_legal(bus.tok_op) ? ST_REDUCE : ST_ERROR;
          end
        end
      end
      ST_REDUCE: begin
        if (op_ptr != '0 && (op_q == OP_EQ || prec(top_op) >= prec(op_q))) begin
          if (opnd_ptr < TWO || div_by_zero) state_n = ST_ERROR;
          else                                do_reduce = 1'b1;
        end else begin
          state_n = (op_q == OP_EQ) ? ST_FINAL : ST_PUSH_OP;
        end
      end
      ST_PUSH_OP: begin
        if (op_ptr == FULL) begin
          state_n = ST_ERROR;
        end else begin
          push_op = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_FINAL: begin
        if (opnd_ptr == '0) begin
          state_n = ST_ERROR;
        end else begin
          do_final = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_ERROR: state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        opnd[i] <= '0;
        ops[i]  <= '0;
      end
      opnd_ptr      <= '0;
      op_ptr        <= '0;
      op_q          <= '0;
      calc_ready_q  <= 1'b0;
      is_equal_q    <= 1'b0;
      calc_error_q  <= 1'b0;
      calc_answer_q <= '0;
    end else begin
      calc_ready_q <= 1'b0;
      is_equal_q   <= 1'b0;
      if (accept) begin
        op_q <= bus.tok_op;
        if (state == ST_DONE) begin
          opnd_ptr     <= '0;
          op_ptr       <= '0;
          calc_error_q <= 1'b0;
        end
      end
      if (push_num) begin
        opnd[base_i] <= bus.tok_number;
        opnd_ptr     <= base_ptr + PW'(1);
      end
      if (do_reduce) begin
        opnd[next_i] <= alu_result;
        opnd_ptr     <= opnd_ptr - PW'(1);
        op_ptr       <= op_ptr - PW'(1);
      end
      if (push_op) begin
        ops[op_push_i] <= op_q;
        op_ptr         <= op_ptr + PW'(1);
        calc_ready_q   <= 1'b1;
      end
      if (do_final) begin
        calc_answer_q <= opnd[top_i];
        opnd_ptr      <= '0;
        op_ptr        <= '0;
        calc_ready_q  <= 1'b1;
        is_equal_q    <= 1'b1;
      end
      if (state == ST_ERROR) begin
        calc_error_q  <= 1'b1;
        calc_answer_q <= '0;
        calc_ready_q  <= 1'b1;
        is_equal_q    <= (op_q == OP_EQ);
      end
    end
  end

  assign bus.tok_ready   = tok_ready;
  assign bus.calc_ready  = calc_ready_q;
  assign bus.is_equal    = is_equal_q;
  assign bus.calc_answer = calc_answer_q;
  assign bus.calc_error  = calc_error_q;

endmodule
